// File: rtl/mux_8_to_1_pkg.sv
// Shared select encoding for the 8:1 multiplexer and its 4:1 building block.
package mux_8_to_1_pkg;

    typedef enum logic [2:0] {
        SEL_R = 3'd0,
        SEL_S = 3'd1,
        SEL_T = 3'd2,
        SEL_U = 3'd3,
        SEL_V = 3'd4,
        SEL_W = 3'd5,
        SEL_X = 3'd6,
        SEL_Y = 3'd7
    } sel_e;

    // Loose select pins become one code, S2 as the MSB; X on any pin stays X.
    function automatic sel_e pack_sel(input logic s2, input logic s1, input logic s0);
        return sel_e'({s2, s1, s0});
    endfunction

endpackage

// File: rtl/mux_8_to_1_if.sv
// Bundle of the multiplexer data, select and result signals for benches and wrappers.
interface mux_8_to_1_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] u;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] m;
    logic             s0;
    logic             s1;
    logic             s2;

    modport master (
        output r, s, t, u, v, w, x, y, s0, s1, s2,
        input  m
    );

    modport slave (
        input  r, s, t, u, v, w, x, y, s0, s1, s2,
        output m
    );
endinterface

// File: rtl/mux_4_to_1.sv
// WIDTH-bit 4:1 selector; an unknown select drives X rather than a default source.
module mux_4_to_1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    // Pick one of four sources, identically for every bit.
    always_comb begin
        y = {WIDTH{1'b0}};
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            2'd3:    y = d;
            default: y = {WIDTH{1'bx}};
        endcase
    end

endmodule

// File: rtl/mux_8_to_1.sv
// 8:1 multiplexer built from two 4:1 stages and a 2:1 stage, with an optional
// synchronously reset output register.
module mux_8_to_1
    import mux_8_to_1_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 1
) (
    input  logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    input  logic [WIDTH-1:0] U,
    input  logic [WIDTH-1:0] V,
    input  logic [WIDTH-1:0] W,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] M,
    input  logic             S0,
    input  logic             S1,
    input  logic             S2,
    input  logic             clk,
    input  logic             rst_n
);

    sel_e             sel_s;
    logic [2:0]       sel_bits_s;
    logic [WIDTH-1:0] lo_s;
    logic [WIDTH-1:0] hi_s;
    logic [WIDTH-1:0] mux_s;

    assign sel_s      = pack_sel(S2, S1, S0);
    assign sel_bits_s = sel_s;

    mux_4_to_1 #(.WIDTH(WIDTH)) u_mux_lo (
        .a   (R),
        .b   (S),
        .c   (T),
        .d   (U),
        .sel (sel_bits_s[1:0]),
        .y   (lo_s)
    );

    mux_4_to_1 #(.WIDTH(WIDTH)) u_mux_hi (
        .a   (V),
        .b   (W),
        .c   (X),
        .d   (Y),
        .sel (sel_bits_s[1:0]),
        .y   (hi_s)
    );

    // Final 2:1 stage on the select MSB; unknown MSB yields X.
    always_comb begin
        mux_s = {WIDTH{1'b0}};
        case (sel_bits_s[2])
            1'b0:    mux_s = lo_s;
            1'b1:    mux_s = hi_s;
            default: mux_s = {WIDTH{1'bx}};
        endcase
    end

    if (REG_OUT != 0) begin : g_reg
        logic [WIDTH-1:0] m_r;

        // Output register reloads every edge; synchronous reset wins over capture.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                m_r <= {WIDTH{1'b0}};
            end else begin
                m_r <= mux_s;
            end
        end

        assign M = m_r;
    end else begin : g_comb
        // Clock and reset have no role in the purely combinational build.
        logic unused_s;
        assign unused_s = &{1'b0, clk, rst_n};
        assign M        = mux_s;
    end

endmodule

// File: tb/tb_mux_8_to_1.sv
// Scoreboard bench for mux_8_to_1: registered 16-bit and 1-bit builds plus a combinational build.
module tb_mux_8_to_1;
    import mux_8_to_1_pkg::*;

    logic clk;
    logic rst_n;
    logic [7:0][15:0] din;
    logic [2:0] sel_v;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    int checks;
    int errors;

    mux_8_to_1_if #(.WIDTH(16)) bus16 ();
    mux_8_to_1_if #(.WIDTH(1))  bus1 ();
    mux_8_to_1_if #(.WIDTH(1))  busc ();

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus16.r = din[0]; assign bus16.s = din[1]; assign bus16.t = din[2]; assign bus16.u = din[3];
    assign bus16.v = din[4]; assign bus16.w = din[5]; assign bus16.x = din[6]; assign bus16.y = din[7];
    assign bus16.s0 = sel_v[0]; assign bus16.s1 = sel_v[1]; assign bus16.s2 = sel_v[2];

    assign bus1.r = din[0][0]; assign bus1.s = din[1][0]; assign bus1.t = din[2][0]; assign bus1.u = din[3][0];
    assign bus1.v = din[4][0]; assign bus1.w = din[5][0]; assign bus1.x = din[6][0]; assign bus1.y = din[7][0];
    assign bus1.s0 = sel_v[0]; assign bus1.s1 = sel_v[1]; assign bus1.s2 = sel_v[2];

    mux_8_to_1 #(.WIDTH(16), .REG_OUT(1)) dut16 (
        .R(bus16.r), .S(bus16.s), .T(bus16.t), .U(bus16.u), .V(bus16.v), .W(bus16.w), .X(bus16.x), .Y(bus16.y),
        .M(bus16.m), .S0(bus16.s0), .S1(bus16.s1), .S2(bus16.s2), .clk(clk), .rst_n(rst_n)
    );

    mux_8_to_1 #(.WIDTH(1), .REG_OUT(1)) dut1 (
        .R(bus1.r), .S(bus1.s), .T(bus1.t), .U(bus1.u), .V(bus1.v), .W(bus1.w), .X(bus1.x), .Y(bus1.y),
        .M(bus1.m), .S0(bus1.s0), .S1(bus1.s1), .S2(bus1.s2), .clk(clk), .rst_n(rst_n)
    );

    mux_8_to_1 #(.WIDTH(1), .REG_OUT(0)) dutc (
        .R(busc.r), .S(busc.s), .T(busc.t), .U(busc.u), .V(busc.v), .W(busc.w), .X(busc.x), .Y(busc.y),
        .M(busc.m), .S0(busc.s0), .S1(busc.s1), .S2(busc.s2), .clk(clk), .rst_n(rst_n)
    );

    // Monitor: one edge after each issued cycle, pop the expected value and compare both registered builds.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            checks++;
            if (bus16.m !== mon_exp) begin
                errors++;
                $display("FAIL reg16: got %h, expected %h at %0t", bus16.m, mon_exp, $time);
            end
            checks++;
            if (bus1.m !== mon_exp[0]) begin
                errors++;
                $display("FAIL reg1: got %b, expected %b at %0t", bus1.m, mon_exp[0], $time);
            end
        end
    end

    // Drive one cycle of stimulus away from the capture edge and queue its expected result.
    task automatic cyc(input logic rst, input logic [2:0] sel, input logic [7:0][15:0] d, input logic [15:0] expv);
        @(negedge clk);
        rst_n = rst;
        sel_v = sel;
        din   = d;
        exp_q.push_back(expv);
    endtask

    logic [15:0] exp_map[8] = '{16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0000};
    logic [15:0] exp_walk[8] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080};

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        sel_v  = 3'd0;
        din    = '0;
        busc.r = 1'b0; busc.s = 1'b0; busc.t = 1'b1; busc.u = 1'b0;
        busc.v = 1'b0; busc.w = 1'b0; busc.x = 1'b0; busc.y = 1'b0;
        busc.s0 = 1'b0; busc.s1 = 1'b1; busc.s2 = 1'b0;

        // Reset with all-ones data and the top select: output must be zero.
        cyc(1'b0, SEL_Y, {8{16'hFFFF}}, 16'h0000);
        cyc(1'b0, SEL_R, {8{16'hFFFF}}, 16'h0000);

        // All-ones sweep.
        for (int k = 0; k < 8; k++) cyc(1'b1, 3'(k), {8{16'hFFFF}}, 16'hFFFF);
        // All-zero sweep.
        for (int k = 0; k < 8; k++) cyc(1'b1, 3'(k), {8{16'h0000}}, 16'h0000);
        // Mapping sweep: R=0 S=0 T=1 U=1 V=1 W=0 X=1 Y=0 (packed Y..R).
        for (int k = 0; k < 8; k++)
            cyc(1'b1, 3'(k), {16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000}, exp_map[k]);
        // Walking one across sources, select tracking the source.
        for (int k = 0; k < 8; k++)
            cyc(1'b1, 3'(k), {16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001}, exp_walk[k]);
        // Mid-stream reset with sel=7, Y=1.
        cyc(1'b1, SEL_Y, {16'h0001, {7{16'h0000}}}, 16'h0001);
        cyc(1'b0, SEL_Y, {16'h0001, {7{16'h0000}}}, 16'h0000);
        cyc(1'b1, SEL_Y, {16'h0001, {7{16'h0000}}}, 16'h0001);

        // Drain the scoreboard within a bounded number of edges.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        // Combinational build: sel 2 -> 5 between edges, T=1, W=0.
        @(negedge clk);
        #1;
        checks++;
        if (busc.m !== 1'b1) begin
            errors++;
            $display("FAIL comb_sel2: got %b, expected 1", busc.m);
        end
        busc.s0 = 1'b1; busc.s1 = 1'b0; busc.s2 = 1'b1;
        #1;
        checks++;
        if (busc.m !== 1'b0) begin
            errors++;
            $display("FAIL comb_sel5: got %b, expected 0", busc.m);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_8_to_1.md
MUX_8_TO_1 -- requirements
Module: mux_8_to_1

Interface
REQ-001 Parameter WIDTH, default 1: bit width of every data input and of M.
REQ-002 Parameter REG_OUT, default 1: 1 means M is registered; 0 means M is combinational and clk/rst_n are unused.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 R  input  WIDTH  data input 0.
REQ-006 S  input  WIDTH  data input 1.
REQ-007 T  input  WIDTH  data input 2.
REQ-008 U  input  WIDTH  data input 3.
REQ-009 V  input  WIDTH  data input 4.
REQ-010 W  input  WIDTH  data input 5.
REQ-011 X  input  WIDTH  data input 6.
REQ-012 Y  input  WIDTH  data input 7.
REQ-013 M  output  WIDTH  selected data.
REQ-014 S0  input  1  select bit 0 (LSB).
REQ-015 S1  input  1  select bit 1.
REQ-016 S2  input  1  select bit 2 (MSB).
REQ-017 Declared port order SHALL be R, S, T, U, V, W, X, Y, M, S0, S1, S2, clk, rst_n, so existing positional instantiations of the first twelve ports stay valid.

Function
REQ-018 Select code sel = {S2,S1,S0} SHALL choose the source: 0 R, 1 S, 2 T, 3 U, 4 V, 5 W, 6 X, 7 Y.
REQ-019 Selection SHALL be applied bitwise, identically, across all WIDTH bits.
REQ-020 With REG_OUT=1, M SHALL equal the source selected by the sel and data sampled at the previous rising edge of clk (latency exactly 1 cycle).
REQ-021 With REG_OUT=1, a change of data or select between edges SHALL NOT affect M until the next rising edge.
REQ-022 With REG_OUT=0, M SHALL follow data and select combinationally with zero cycle latency.
REQ-023 No enable or hold exists: with REG_OUT=1, M SHALL reload on every rising edge while rst_n is high.
REQ-024 Non-binary select (X/Z) in simulation SHALL propagate X to M, with no silent defaulting.
REQ-025 The block SHALL contain no state other than the WIDTH-bit output register.

Reset
REQ-026 With REG_OUT=1, rst_n low at a rising edge SHALL set M to all zeros at that edge, regardless of select and data.
REQ-027 Reset SHALL take priority over data capture.
REQ-028 Asserting rst_n low mid-stream SHALL clear M at the next edge.
REQ-029 On the first edge with rst_n high, M SHALL load the currently selected input.
REQ-030 rst_n SHALL have no asynchronous effect on M.

Structure
REQ-031 A shared package SHALL define the 3-bit select type and the named codes SEL_R=0 through SEL_Y=7.
REQ-032 The select path SHALL be built as two 4:1 stages (sel[1:0]) followed by a 2:1 stage on S2.
REQ-033 The 4:1 stage SHALL be a single sub-module, mux_4_to_1, parameterized by WIDTH.
REQ-034 The output register SHALL be a generate-selected block controlled by REG_OUT.

Verification
REQ-035 Mapping sweep: WIDTH=1, R=0 S=0 T=1 U=1 V=1 W=0 X=1 Y=0; sweep sel 0..7 one value per cycle -> M = 0,0,1,1,1,0,1,0, each one cycle after its sel.
REQ-036 All-zero inputs: sweep sel 0..7 -> M=0 for every code.
REQ-037 All-one inputs: sweep sel 0..7 -> M=1 for every code after the first post-reset edge.
REQ-038 Walking one: WIDTH=16, input k = 16'h0001<<k, sel=k -> M = 16'h0001<<k one cycle later, for k=0..7.
REQ-039 Reset: hold sel=7, Y=1, and drive rst_n=0 for one edge mid-sweep -> M=0 at that edge, then M=1 at the following edge.
REQ-040 Combinational build: REG_OUT=0, change sel from 2 to 5 with T=1, W=0 -> M goes from 1 to 0 in the same timestep with no clock edge.
